multi_alu: RTL and testbench

- Board-level 32-bit ALU experiment block.
- Operands A and B and the opcode are entered from a 32-bit switch bank (sw). Three strobe inputs load A, load B and capture the ALU result F.
- F is registered and shown as 8 hex digits on a time-multiplexed seven-segment display. Flags FR = {ZF,SF,OF,CF} drive LEDs.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/seg_scan.sv | 31 +++
 rtl/multi_alu.sv | 93 +++++++++
 tb/tb_multi_alu.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants, flag bit positions and the hex-to-7-segment glyph helper
package alu_pkg;
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam int FR_ZF = 3;
  localparam int FR_SF = 2;
  localparam int FR_OF = 1;
  localparam int FR_CF = 0;
  function automatic logic [6:0] hex7(input logic [3:0] d);
    case (d)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction
endpackage

// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed 8-digit hex display scanner
module seg_scan
  import alu_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] value,
  output logic [7:0]  seg,
  output logic [2:0]  which
);
  localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  logic [PW-1:0] r_pre;
  logic [2:0]    r_which;
  logic          w_wrap;
  assign w_wrap = r_pre == PW'(SCAN_DIV - 1);
  assign which  = r_which;
  // prescaler wraps every SCAN_DIV clocks and advances the digit index
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pre   <= '0;
      r_which <= '0;
    end else begin
      r_pre <= w_wrap ? '0 : r_pre + 1'b1;
      if (w_wrap) r_which <= r_which + 3'd1;
    end
  end
  // decode the nibble of the active digit; dp is never lit
  always_comb seg = {1'b0, hex7(value[{r_which, 2'b00} +: 4])};
endmodule

// File: rtl/multi_alu.sv
// multi_alu: switch-driven 32-bit ALU with synchronized load/capture strobes and hex display
module multi_alu
  import alu_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_A,
  input  logic        clk_B,
  input  logic        clk_F,
  input  logic [31:0] sw,
  output logic [3:0]  FR,
  output logic [7:0]  seg,
  output logic [2:0]  which
);
  logic [2:0]  r_s0, r_s1, r_s2, r_s3;
  logic [2:0]  w_pulse;
  logic [31:0] r_a, r_b, r_f, w_res;
  logic [3:0]  r_fr, w_op;
  logic [32:0] w_sum, w_dif;
  logic        w_of, w_cf;
  // a strobe counts only after two consecutive synchronized highs, so one-cycle glitches never load
  assign w_pulse = r_s1 & r_s2 & ~r_s3;
  assign w_op    = sw[31:28];
  assign w_sum   = {1'b0, r_a} + {1'b0, r_b};
  assign w_dif   = {1'b0, r_a} - {1'b0, r_b};
  assign FR      = r_fr;
  // two-stage synchronizer plus edge/qualification history for {F,B,A} strobes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s0 <= '0;
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s0 <= {clk_F, clk_B, clk_A};
      r_s1 <= r_s0;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end
  // operand and result registers; capture sees the operands from before any same-cycle load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a  <= '0;
      r_b  <= '0;
      r_f  <= '0;
      r_fr <= '0;
    end else begin
      if (w_pulse[0]) r_a <= sw;
      if (w_pulse[1]) r_b <= sw;
      if (w_pulse[2]) begin
        r_f  <= w_res;
        r_fr <= {w_res == 32'd0, w_res[31], w_of, w_cf};
      end
    end
  end
  // combinational ALU; only ADD and SUB produce overflow and carry
  always_comb begin
    w_res = '0;
    w_of  = 1'b0;
    w_cf  = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_res = w_sum[31:0];
        w_cf  = w_sum[32];
        w_of  = (r_a[31] == r_b[31]) && (w_sum[31] != r_a[31]);
      end
      OP_SUB: begin
        w_res = w_dif[31:0];
        w_cf  = w_dif[32];
        w_of  = (r_a[31] != r_b[31]) && (w_dif[31] != r_a[31]);
      end
      OP_AND:  w_res = r_a & r_b;
      OP_OR:   w_res = r_a | r_b;
      OP_XOR:  w_res = r_a ^ r_b;
      OP_SLL:  w_res = r_a << r_b[4:0];
      OP_SRL:  w_res = r_a >> r_b[4:0];
      OP_SRA:  w_res = $signed(r_a) >>> r_b[4:0];
      OP_SLT:  w_res = {31'd0, $signed(r_a) < $signed(r_b)};
      OP_SLTU: w_res = {31'd0, r_a < r_b};
      default: w_res = '0;
    endcase
  end
  seg_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk   (clk),
    .rst_n (rst_n),
    .value (r_f),
    .seg   (seg),
    .which (which)
  );
endmodule

// File: tb/tb_multi_alu.sv
// tb_multi_alu: randomized and directed checks of multi_alu against an arithmetic reference model
module tb_multi_alu;
  logic        clk = 0, rst_n = 0, clk_A = 0, clk_B = 0, clk_F = 0;
  logic [31:0] sw = 0;
  logic [3:0]  FR;
  logic [7:0]  seg;
  logic [2:0]  which;
  int          n_chk = 0, n_err = 0;
  logic [31:0] ma = 0, mb = 0, mf = 0;
  logic [3:0]  mfr = 0;
  logic [6:0]  glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  multi_alu #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .clk_A(clk_A), .clk_B(clk_B), .clk_F(clk_F),
    .sw(sw), .FR(FR), .seg(seg), .which(which)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] f, output logic [3:0] fl);
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint lim = longint'(1) <<< 31;
    longint r;
    logic of = 0, cf = 0;
    case (op)
      4'h0: begin
        r  = ua + ub;
        f  = r[31:0];
        cf = r >= (longint'(1) <<< 32);
        of = (sa + sb >= lim) || (sa + sb < -lim);
      end
      4'h8: begin
        r  = ua - ub;
        f  = r[31:0];
        cf = ua < ub;
        of = (sa - sb >= lim) || (sa - sb < -lim);
      end
      4'h7: f = a & b;
      4'h6: f = a | b;
      4'h4: f = a ^ b;
      4'h1: f = a << b[4:0];
      4'h5: f = a >> b[4:0];
      4'hD: f = a[31] ? ~((~a) >> b[4:0]) : a >> b[4:0];
      4'h2: f = (sa < sb) ? 32'd1 : 32'd0;
      4'h3: f = (ua < ub) ? 32'd1 : 32'd0;
      default: f = 0;
    endcase
    fl = {f == 0, f[31], of, cf};
  endfunction

  task automatic strobe(input logic a, input logic b, input logic f, input logic [31:0] v, input int hold);
    logic [31:0] nf;
    logic [3:0]  nfr;
    @(negedge clk);
    sw = v; clk_A = a; clk_B = b; clk_F = f;
    repeat (hold) @(negedge clk);
    clk_A = 0; clk_B = 0; clk_F = 0;
    repeat (4) @(negedge clk);
    if (hold >= 2) begin
      ref_alu(v[31:28], ma, mb, nf, nfr);
      if (f) begin mf = nf; mfr = nfr; end
      if (a) ma = v;
      if (b) mb = v;
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] ef, input logic [3:0] efr);
    logic [63:0] obs = '0, expv = '0;
    for (int i = 0; i < 8; i++) expv[i*8 +: 8] = {1'b0, glyph[ef[i*4 +: 4]]};
    repeat (40) begin
      @(negedge clk);
      obs[which*8 +: 8] = seg;
    end
    check({tag, ".FR"}, 64'(FR), 64'(efr));
    check({tag, ".F"}, obs, expv);
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    strobe(1, 0, 0, a, 3);
    strobe(0, 1, 0, b, 3);
    strobe(0, 0, 1, {op, 28'h0}, 3);
  endtask

  initial begin
    int cnt;
    logic [2:0] prev;
    repeat (3) @(negedge clk);
    check("reset.FR", 64'(FR), 0);
    check("reset.which", 64'(which), 0);
    check("reset.seg", 64'(seg), 64'h3F);
    rst_n = 1;
    do_op(5, 3, 4'h0);                check_out("add53", 32'h8, 4'b0000);
    strobe(0, 1, 0, 2, 3);
    strobe(0, 0, 1, 32'h8000_0000, 3); check_out("sub52", 32'h3, 4'b0000);
    do_op(32'h0000F0F0, 32'h0000FF00, 4'h7); check_out("and", 32'h0000F000, 4'b0000);
    strobe(0, 0, 1, 32'h6000_0000, 3);       check_out("or",  32'h0000FFF0, 4'b0000);
    strobe(0, 0, 1, 32'h4000_0000, 3);       check_out("xor", 32'h00000FF0, 4'b0000);
    do_op(1, 4, 4'h1);                       check_out("sll", 32'h10, 4'b0000);
    do_op(32'h8000_0000, 4, 4'h5);           check_out("srl", 32'h08000000, 4'b0000);
    strobe(0, 0, 1, 32'hD000_0000, 3);       check_out("sra", 32'hF8000000, 4'b0100);
    do_op(32'hFFFF_FFFB, 3, 4'h2);           check_out("slt", 32'h1, 4'b0000);
    strobe(0, 0, 1, 32'h3000_0000, 3);       check_out("sltu", 32'h0, 4'b1000);
    do_op(32'h7FFF_FFFF, 1, 4'h0);           check_out("add_ovf", 32'h80000000, 4'b0110);
    do_op(0, 1, 4'h8);                       check_out("sub_borrow", 32'hFFFFFFFF, 4'b0101);
    strobe(1, 0, 0, 32'hDEAD_BEEF, 1);
    strobe(0, 0, 1, 32'h0000_0000, 3);       check_out("short_strobe", 32'h1, 4'b0000);
    strobe(1, 1, 1, 32'h8000_0005, 3);       check_out("simul", 32'hFFFFFFFF, 4'b0101);
    strobe(0, 0, 1, 32'h8000_0000, 3);       check_out("simul_ab", 32'h0, 4'b1000);
    do_op(32'h1234_5678, 0, 4'h0);           check_out("disp", 32'h12345678, 4'b0000);
    @(negedge clk);
    prev = which; cnt = 0;
    while (which == prev && cnt < 20) begin @(negedge clk); cnt++; end
    for (int s = 0; s < 8; s++) begin
      prev = which; cnt = 0;
      do begin @(negedge clk); cnt++; end while (which == prev && cnt < 20);
      check("scan_step", {cnt, 29'd0, which}, {32'd4, 29'd0, 3'(prev + 3'd1)});
    end
    for (int i = 0; i < 16; i++) begin
      logic [31:0] a = $urandom, b = $urandom;
      logic [3:0]  op = 4'($urandom_range(0, 15));
      if (i % 4 == 1) b = $urandom_range(0, 40);
      if (i % 4 == 2) b = a;
      do_op(a, b, op);
      check_out("rand", mf, mfr);
    end
    @(negedge clk);
    sw = 32'hA5A5_A5A5; clk_A = 1; clk_B = 1; clk_F = 1;
    repeat (2) @(negedge clk);
    rst_n = 0; clk_A = 0; clk_B = 0; clk_F = 0;
    repeat (2) @(negedge clk);
    check("midrst.FR", 64'(FR), 0);
    check("midrst.which", 64'(which), 0);
    check("midrst.seg", 64'(seg), 64'h3F);
    rst_n = 1;
    ma = 0; mb = 0; mf = 0; mfr = 0;
    strobe(0, 0, 1, 32'h0000_0000, 3);       check_out("midrst_cap", 32'h0, 4'b1000);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
